instr_queue: RTL and testbench

- Instruction queue between the fetch stage (PC register, branch adders, instruction memory) and the decode/control stage of the 64-bit LEGv8 CPU.
- Buffers fetched {PC, instruction} pairs in a circular FIFO and decouples fetch from decode with valid/ready handshakes.
- A branch-redirect flush discards all queued entries in one cycle.

---
 rtl/instr_queue.sv | 80 ++++++++
 tb/tb_instr_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instr} pairs with one-cycle flush.
// Optional same-cycle bypass when empty, enabled by INSTR_QUEUE_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  input  logic               flush,
  output logic [CW-1:0]      count
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop, byp_take;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    in_ready  = !full && !flush;
    out_valid = !empty && !flush;
    out_pc    = empty ? '0 : mem[rd_ptr].pc;
    out_instr = empty ? '0 : mem[rd_ptr].instr;
    byp_take  = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    // Empty queue: present the fetch entry directly; if taken, it never touches storage.
    if (empty && !flush) begin
      out_valid = in_valid;
      out_pc    = in_pc;
      out_instr = in_instr;
      byp_take  = in_valid && out_ready;
    end
`endif
  end

  assign push = in_valid && in_ready && !byp_take;
  assign pop  = out_valid && out_ready && !byp_take;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based reference model of the FIFO contents.
module tb_instr_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, flush;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [95:0] sb [$];
  logic [63:0] npc;

  instr_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'h91000421 + 32'(pc >> 2);
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare against the model, then advance the model across the edge.
  task automatic step(input bit iv, input logic [63:0] pc, input bit ordy, input bit fl);
    bit          emp, exp_ir, exp_ov, byp;
    logic [95:0] exp_e;
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy; flush = fl;
    #1;
    emp    = (sb.size() == 0);
    exp_ir = (sb.size() < DEPTH) && !fl;
    exp_ov = !emp && !fl;
    exp_e  = emp ? 96'h0 : sb[0];
    byp    = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    if (emp && !fl) begin
      exp_ov = iv;
      exp_e  = {pc, instr_of(pc)};
      byp    = iv && ordy;
    end
`endif
    chk("count", 96'(count), 96'(sb.size()));
    chk("in_ready", 96'(in_ready), 96'(exp_ir));
    chk("out_valid", 96'(out_valid), 96'(exp_ov));
    if (!fl) chk("out_entry", {out_pc, out_instr}, exp_e);
    if (fl) sb.delete();
    else if (!byp) begin
      if (exp_ov && ordy) void'(sb.pop_front());
      if (exp_ir && iv) sb.push_back({pc, instr_of(pc)});
    end
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0; flush = 0;
    #1;
    chk("rst_count", 96'(count), 96'd0);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out_entry", {out_pc, out_instr}, 96'h0);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_in_ready", 96'(in_ready), 96'd1);

    // Async reset in the middle of a cycle with three entries held
    for (int i = 0; i < 3; i++) step(1, 64'h100 + 64'(i * 4), 0, 0);
    in_valid = 0; out_ready = 0;
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_count", 96'(count), 96'd0);
    chk("mid_rst_out_valid", 96'(out_valid), 96'd0);
    chk("mid_rst_out_instr", 96'(out_instr), 96'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    #1 chk("mid_rst_in_ready", 96'(in_ready), 96'd1);

    // Fill to DEPTH, refuse a fifth push, then drain in order
    for (int i = 0; i < 4; i++) step(1, 64'(i * 4), 0, 0);
    step(1, 64'h10, 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

    // Concurrent push/pop at count 2 across pointer wrap
    npc = 64'h200;
    for (int i = 0; i < 2; i++) begin step(1, npc, 0, 0); npc += 4; end
    for (int i = 0; i < 10; i++) begin step(1, npc, 1, 0); npc += 4; end

    // Full with pop: push refused, then accepted next cycle
    for (int i = 0; i < 2; i++) begin step(1, npc, 0, 0); npc += 4; end
    step(1, npc, 1, 0);
    step(1, npc, 0, 0);
    npc += 4;
    step(0, '0, 1, 0);

    // Flush at count 3 with a pending fetch of PC 0x40
    step(1, 64'h40, 0, 1);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);

    // Empty queue, fetch 0x80 with decode ready
    step(1, 64'h80, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
